trigger_monitor: RTL

Receive-side counterpart of the trigger clock generator. Takes an externally returned or looped-back trigger square wave and measures its period and high time in i_clk cycles. Checks both against expected values with a tolerance, declares lock after consecutive good periods, and flags a lost trigger. Sits between the trigger input pin and the control and status logic.

---
 rtl/trigger_pkg.sv | 15 +
 rtl/sync_edge.sv | 33 +++
 rtl/trigger_monitor.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/trigger_pkg.sv
// Shared definitions for the trigger generator/monitor pair, so both ends
// agree on the nominal trigger timing and the monitor state encoding.
package trigger_pkg;

  localparam int TRIG_CNT_W = 26;
  localparam int EXP_PERIOD = 2_500_000;
  localparam int EXP_HIGH   = 1_250_000;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    TRACK
  } trig_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a
// previous-level register that yields single-cycle rise/fall strobes.
module sync_edge (
  input  logic i_clk,
  input  logic rst,
  input  logic i_async,
  output logic s,
  output logic rise,
  output logic fall
);

  logic meta;
  logic s_d;

  // Synchronizer chain and delayed copy for edge detection.
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge value of its neighbour; = here would collapse the chain.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      meta <= 1'b0;
      s    <= 1'b0;
      s_d  <= 1'b0;
    end else begin
      meta <= i_async;
      s    <= meta;
      s_d  <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

endmodule

// File: rtl/trigger_monitor.sv
// Measures period and high time of a returned trigger square wave,
// checks both against expected values, tracks lock and detects loss.
module trigger_monitor
  import trigger_pkg::*;
#(
  parameter int CNT_W      = TRIG_CNT_W,
  parameter int EXP_PERIOD = trigger_pkg::EXP_PERIOD,
  parameter int EXP_HIGH   = trigger_pkg::EXP_HIGH,
  parameter int TOL        = 1_000,
  parameter int TIMEOUT    = 5_000_000,
  parameter int LOCK_N     = 4
) (
  input  logic             i_clk,
  input  logic             rst,
  input  logic             i_trig,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high,
  output logic             o_valid,
  output logic             o_err_period,
  output logic             o_locked,
  output logic             o_err_timeout
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);

  // Tolerance arithmetic runs one bit wider than the counters so the
  // absolute difference can never wrap.
  localparam logic [CNT_W:0]    EXP_P_V   = (CNT_W + 1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]    EXP_H_V   = (CNT_W + 1)'(EXP_HIGH);
  localparam logic [CNT_W:0]    TOL_V     = (CNT_W + 1)'(TOL);
  localparam logic [CNT_W-1:0]  TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [GOOD_W-1:0] LOCK_V    = GOOD_W'(LOCK_N);

  function automatic logic out_of_tol(input logic [CNT_W:0] meas,
                                      input logic [CNT_W:0] exp_v);
    logic [CNT_W:0] diff;
    diff = (meas >= exp_v) ? (meas - exp_v) : (exp_v - meas);
    return diff > TOL_V;
  endfunction

  logic              s;
  logic              rise;
  logic              fall;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [CNT_W-1:0]  hi_hold;
  logic [GOOD_W-1:0] good_cnt;
  logic [GOOD_W-1:0] good_inc;
  trig_state_e       state_q;
  trig_state_e       state_d;
  logic              report;
  logic              timeout_hit;
  logic              meas_err;

  sync_edge u_sync (
    .i_clk   (i_clk),
    .rst     (rst),
    .i_async (i_trig),
    .s       (s),
    .rise    (rise),
    .fall    (fall)
  );

  // Period and high-time counters; hi_hold latches the high time at each fall.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      cnt     <= '0;
      hi_cnt  <= '0;
      hi_hold <= '0;
    end else begin
      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      if (rise) begin
        hi_cnt <= CNT_W'(1);
      end else if (s && hi_cnt != CNT_MAX) begin
        hi_cnt <= hi_cnt + 1'b1;
      end

      if (fall && state_q != IDLE) begin
        hi_hold <= hi_cnt;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, report/timeout strobes and tolerance check; a rise always
  // takes priority over a timeout reached on the same cycle.
  // NOTE: every signal gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    report      = 1'b0;
    timeout_hit = 1'b0;
    meas_err    = out_of_tol({1'b0, cnt}, EXP_P_V) |
                  out_of_tol({1'b0, hi_hold}, EXP_H_V);
    good_inc    = (good_cnt == LOCK_V) ? good_cnt : good_cnt + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = ARM;
      end
      ARM, TRACK: begin
        if (rise) begin
          state_d = TRACK;
          report  = 1'b1;
        end else if (cnt >= TIMEOUT_V) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reported measurements, lock tracking and trigger-lost flag.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      o_period      <= '0;
      o_high        <= '0;
      o_valid       <= 1'b0;
      o_err_period  <= 1'b0;
      o_locked      <= 1'b0;
      o_err_timeout <= 1'b0;
      good_cnt      <= '0;
    end else begin
      o_valid      <= report;
      o_err_period <= report & meas_err;

      if (report) begin
        o_period <= cnt;
        o_high   <= hi_hold;
        if (meas_err) begin
          good_cnt <= '0;
          o_locked <= 1'b0;
        end else begin
          good_cnt <= good_inc;
          o_locked <= (good_inc == LOCK_V);
        end
      end

      if (timeout_hit) begin
        o_err_timeout <= 1'b1;
        o_locked      <= 1'b0;
        good_cnt      <= '0;
      end else if (rise) begin
        o_err_timeout <= 1'b0;
      end
    end
  end

endmodule
